// File: rtl/key_pkg.sv
// Shared types and helpers for the key encoder: FSM state type and the
// 4-to-2 priority encode that inverts the 2-to-4 decoder.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } key_state_e;

  // Highest set index wins: 0001->00, 001x->01, 01xx->10, 1xxx->11.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    else           r = 2'd0;
    return r;
  endfunction

  function automatic logic multi4(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/key_encoder_sync2.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to zero.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_encoder.sv
// Debounced 4-button encoder emitting a one-cycle valid strobe per accepted press.
// Optional auto-repeat while held is enabled by defining KEY_ENCODER_REPEAT_EN.
module key_encoder
  import key_pkg::*;
#(
  parameter int DEB_CNT = 16,
  parameter int REP_DLY = 64,
  parameter int REP_PER = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [1:0] code,
  output logic       valid,
  output logic       multi
);

`ifdef KEY_ENCODER_REPEAT_EN
  localparam int CNT_MAX = (DEB_CNT > REP_DLY) ? DEB_CNT : REP_DLY;
`else
  localparam int CNT_MAX = DEB_CNT;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);

  logic [3:0]    ks;
  key_state_e    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          multi_q, multi_d;

`ifdef KEY_ENCODER_REPEAT_EN
  localparam logic [CW-1:0] REP_DLY_LAST = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] REP_PER_LAST = CW'(REP_PER - 1);
  // Set on every entry to HELD so the first repeat waits the longer delay.
  logic rep_first_q, rep_first_d;
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{REP_DLY, REP_PER};
`endif

  sync2 #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key),
    .q   (ks)
  );

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    multi_d = multi_q;
    valid_d = 1'b0;
`ifdef KEY_ENCODER_REPEAT_EN
    rep_first_d = rep_first_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ks != 4'd0) begin
          cand_d  = ks;
          cnt_d   = '0;
          state_d = ST_DEB_PRESS;
        end
      end
      ST_DEB_PRESS: begin
        if (ks == 4'd0) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (ks != cand_q) begin
          cand_d = ks;
          cnt_d  = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = ST_HELD;
          valid_d = 1'b1;
          code_d  = enc4(cand_q);
          multi_d = multi4(cand_q);
`ifdef KEY_ENCODER_REPEAT_EN
          rep_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (ks == 4'd0) begin
          cnt_d   = '0;
          state_d = ST_DEB_REL;
        end
`ifdef KEY_ENCODER_REPEAT_EN
        else if (cnt_q == (rep_first_q ? REP_DLY_LAST : REP_PER_LAST)) begin
          cnt_d       = '0;
          valid_d     = 1'b1;
          rep_first_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      ST_DEB_REL: begin
        if (ks != 4'd0) begin
          cnt_d   = '0;
          state_d = ST_HELD;
`ifdef KEY_ENCODER_REPEAT_EN
          rep_first_d = 1'b1;
`endif
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

`ifdef KEY_ENCODER_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_first_q <= 1'b0;
    else     rep_first_q <= rep_first_d;
  end
`endif

  assign code  = code_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_key_encoder.sv
// Directed bench for key_encoder with DEB_CNT=4, REP_DLY=8, REP_PER=3.
// Edge numbers count rising edges after the step's key change was applied.
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'd0;
  logic [1:0] code;
  logic       valid;
  logic       multi;

  int total = 0;
  int bad   = 0;
  int edge_no;
  int nstb;
  int stb_edge [16];

  key_encoder #(.DEB_CNT(4), .REP_DLY(8), .REP_PER(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .code  (code),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 ns after each edge and logging strobes.
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (valid !== 1'b0) begin
        if (nstb < 16) stb_edge[nstb] = edge_no;
        nstb++;
      end
    end
  endtask

  task automatic start_step();
    edge_no = 0;
    nstb    = 0;
    for (int i = 0; i < 16; i++) stb_edge[i] = -1;
  endtask

`ifdef KEY_ENCODER_REPEAT_EN
  int exp_rep [7] = '{7, 15, 18, 21, 24, 27, 30};
`endif

  initial begin
    // Reset state
    start_step();
    run(3);
    chk("reset_valid", valid, 0);
    chk("reset_code", code, 0);
    chk("reset_multi", multi, 0);
    rst = 1'b0;
    run(2);
    chk("idle_no_strobe", nstb, 0);

    // Single key 0100 held 20 cycles
    start_step();
    key = 4'b0100;
    run(20);
    chk("k0100_count", nstb, 1);
    chk("k0100_edge", stb_edge[0], 7);
    chk("k0100_code", code, 2);
    chk("k0100_multi", multi, 0);
    start_step();
    key = 4'b0000;
    run(10);
    chk("k0100_release_count", nstb, 0);
    $display("step k0100: strobes=1 code=%0d multi=%0d", code, multi);

    // Bouncing 0010 every 2 cycles never qualifies
    start_step();
    for (int i = 0; i < 5; i++) begin
      key = 4'b0010;
      run(2);
      key = 4'b0000;
      run(2);
    end
    run(10);
    chk("bounce_count", nstb, 0);
    chk("bounce_code_hold", code, 2);
    $display("step bounce: strobes=%0d", nstb);

    // Two keys 1010, then change to 0001 while held
    start_step();
    key = 4'b1010;
    run(15);
    chk("k1010_count", nstb, 1);
    chk("k1010_edge", stb_edge[0], 7);
    chk("k1010_code", code, 3);
    chk("k1010_multi", multi, 1);
    start_step();
    key = 4'b0001;
    run(15);
    chk("held_change_count", nstb, 0);
    chk("held_change_code", code, 3);
    start_step();
    key = 4'b0000;
    run(10);
    chk("k1010_release_count", nstb, 0);
    chk("k1010_multi_hold", multi, 1);
    $display("step k1010: code=%0d multi=%0d", code, multi);

    // 0001 with a 2-cycle release glitch at cycle 12, held to cycle 30
    start_step();
    key = 4'b0001;
    run(12);
    key = 4'b0000;
    run(2);
    key = 4'b0001;
    run(16);
    chk("glitch_count", nstb, 1);
    chk("glitch_edge", stb_edge[0], 7);
    chk("glitch_code", code, 0);
    chk("glitch_multi", multi, 0);
    start_step();
    key = 4'b0000;
    run(10);
    chk("glitch_release_count", nstb, 0);
    $display("step glitch: strobes=1 code=%0d", code);

    // Reset 3 cycles after 1000 accepted, key kept held
    start_step();
    key = 4'b1000;
    run(10);
    chk("prerst_count", nstb, 1);
    chk("prerst_code", code, 3);
    rst = 1'b1;
    #1;
    chk("inrst_valid", valid, 0);
    chk("inrst_code", code, 0);
    chk("inrst_multi", multi, 0);
    start_step();
    run(2);
    chk("inrst_count", nstb, 0);
    rst = 1'b0;
    start_step();
    run(10);
    chk("postrst_count", nstb, 1);
    chk("postrst_edge", stb_edge[0], 7);
    chk("postrst_code", code, 3);
    start_step();
    key = 4'b0000;
    run(10);
    $display("step reset: new strobe at edge 7 code=%0d", code);

    // 0010 held 30 cycles: single strobe, or auto-repeat when enabled
    start_step();
    key = 4'b0010;
    run(30);
`ifdef KEY_ENCODER_REPEAT_EN
    chk("rep_count", nstb, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("rep_edge%0d", i), stb_edge[i], exp_rep[i]);
`else
    chk("norep_count", nstb, 1);
    chk("norep_edge", stb_edge[0], 7);
`endif
    chk("hold30_code", code, 1);
    chk("hold30_multi", multi, 0);
    key = 4'b0000;
    run(10);
    $display("step hold30: strobes=%0d code=%0d", nstb, code);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
